// File: rtl/dac_pkg.sv
// Shared types and default constants for the PWM DAC sharing scheduler.
// Also holds the modulo-increment helper used for round-robin pointers.
package dac_pkg;

    localparam int unsigned DEF_DATA_W   = 8;
    localparam int unsigned DEF_HOLD_W   = 8;
    localparam int unsigned DEF_IDLE_VAL = 0;

    typedef enum logic {
        StIdle,
        StActive
    } sched_state_e;

    // Increment modulo n without relying on n being a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: scans requests starting at the pointer rr_i and
// returns the first one found as a one-hot grant plus its index.
module rr_arbiter
    import dac_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = rr_i;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
            cand = IDX_W'(wrap_inc(32'(cand), N_REQ));
        end
    end

endmodule

// File: rtl/dac_share_sched.sv
// Round-robin scheduler sharing one PWM DAC between requesters. The DAC code only
// changes on PWM period boundaries so no period carries a truncated duty cycle.
module dac_share_sched
    import dac_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned HOLD_W   = DEF_HOLD_W,
    parameter int unsigned IDLE_VAL = DEF_IDLE_VAL
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    input  logic [N_REQ*HOLD_W-1:0]    req_hold,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic [DATA_W-1:0]          digital_value,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic                       period_tick
);

    localparam int unsigned IDX_W = $clog2(N_REQ);

    logic [DATA_W-1:0] pcnt_q, pcnt_d;
    sched_state_e      state_q, state_d;
    logic [DATA_W-1:0] value_q, value_d;
    logic [HOLD_W-1:0] hcnt_q, hcnt_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  rr_q, rr_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              tick_q, tick_d;

    logic              boundary;
    logic              grant_now;
    logic [N_REQ-1:0]  owner_oh;
    logic [N_REQ-1:0]  arb_req;
    logic [N_REQ-1:0]  arb_gnt;
    logic [IDX_W-1:0]  arb_idx;
    logic [DATA_W-1:0] sel_data;
    logic [HOLD_W-1:0] sel_hold;

    assign boundary = &pcnt_q;
    assign owner_oh = {{(N_REQ-1){1'b0}}, 1'b1} << owner_q;
    // The current owner may not win the boundary on which its own hold expires.
    assign arb_req  = (state_q == StActive) ? (req & ~owner_oh) : req;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req_i (arb_req),
        .rr_i  (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    always_comb begin
        sel_data = '0;
        sel_hold = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (arb_gnt[i]) begin
                sel_data = req_data[i*DATA_W +: DATA_W];
                sel_hold = req_hold[i*HOLD_W +: HOLD_W];
            end
        end
    end

    always_comb begin
        pcnt_d    = pcnt_q + 1'b1;
        tick_d    = boundary;
        state_d   = state_q;
        value_d   = value_q;
        hcnt_d    = hcnt_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gnt_d     = '0;
        done_d    = '0;
        grant_now = 1'b0;

        if (boundary) begin
            unique case (state_q)
                StIdle: begin
                    grant_now = en && (|arb_req);
                end
                StActive: begin
                    hcnt_d = hcnt_q - 1'b1;
                    if (!en) begin
                        state_d = StIdle;
                        value_d = DATA_W'(IDLE_VAL);
                    end else if (hcnt_q == HOLD_W'(1)) begin
                        done_d = owner_oh;
                        if (|arb_req) begin
                            grant_now = 1'b1;
                        end else begin
                            state_d = StIdle;
                            value_d = DATA_W'(IDLE_VAL);
                        end
                    end
                end
                default: ;
            endcase

            if (grant_now) begin
                state_d = StActive;
                value_d = sel_data;
                hcnt_d  = (sel_hold == '0) ? HOLD_W'(1) : sel_hold;
                owner_d = arb_idx;
                rr_d    = IDX_W'(wrap_inc(32'(arb_idx), N_REQ));
                gnt_d   = arb_gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= '0;
            state_q <= StIdle;
            value_q <= DATA_W'(IDLE_VAL);
            hcnt_q  <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            tick_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            state_q <= state_d;
            value_q <= value_d;
            hcnt_q  <= hcnt_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign gnt           = gnt_q;
    assign done          = done_q;
    assign digital_value = value_q;
    assign owner         = owner_q;
    assign busy          = (state_q == StActive);
    assign period_tick   = tick_q;

    // Pulses can only appear in the first cycle of a period.
    a_pulse_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q) && $onehot0(done_q));
    a_pulse_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        (|gnt_q || |done_q) |-> (pcnt_q == '0));
    a_hold_live: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (hcnt_q != '0));

endmodule

// File: tb/tb_dac_share_sched.sv
// Randomised and directed bench for dac_share_sched against a boundary-level
// behavioural model of the sharing rules.
module tb_dac_share_sched;

    localparam int N      = 4;
    localparam int DW     = 8;
    localparam int HW     = 8;
    localparam int PERIOD = 256;
    localparam int IDLE   = 0;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [N-1:0]      req;
    logic [N*DW-1:0]   req_data;
    logic [N*HW-1:0]   req_hold;
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [DW-1:0]     digital_value;
    logic [1:0]        owner;
    logic              busy;
    logic              period_tick;

    dac_share_sched #(
        .N_REQ    (N),
        .DATA_W   (DW),
        .HOLD_W   (HW),
        .IDLE_VAL (IDLE)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .req           (req),
        .req_data      (req_data),
        .req_hold      (req_hold),
        .gnt           (gnt),
        .done          (done),
        .digital_value (digital_value),
        .owner         (owner),
        .busy          (busy),
        .period_tick   (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: position within the period, owner, periods left, and rr pointer.
    int           m_pcnt;
    bit           m_busy;
    int           m_owner;
    int           m_left;
    int           m_rr;
    logic [DW-1:0] m_val;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_done;
    bit           m_tick;

    logic [N-1:0] rearm;
    logic [N-1:0] relift;

    task automatic model_reset();
        m_pcnt  = 0;
        m_busy  = 0;
        m_owner = 0;
        m_left  = 0;
        m_rr    = 0;
        m_val   = DW'(IDLE);
        m_gnt   = '0;
        m_done  = '0;
        m_tick  = 0;
    endtask

    task automatic model_next();
        bit bnd;
        bit arb;
        int excl;
        int win;
        int hv;
        bnd    = (m_pcnt == PERIOD - 1);
        m_gnt  = '0;
        m_done = '0;
        m_tick = bnd;
        arb    = 0;
        excl   = -1;
        win    = -1;
        if (bnd) begin
            if (!m_busy) begin
                arb = en && (req != '0);
            end else begin
                m_left--;
                if (!en) begin
                    m_busy = 0;
                    m_val  = DW'(IDLE);
                end else if (m_left == 0) begin
                    m_done[m_owner] = 1'b1;
                    m_busy = 0;
                    m_val  = DW'(IDLE);
                    excl   = m_owner;
                    arb    = 1;
                end
            end
            if (arb) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_rr + k) % N;
                    if (win < 0 && req[c] && c != excl) win = c;
                end
                if (win >= 0) begin
                    hv         = int'(req_hold[win*HW +: HW]);
                    m_busy     = 1;
                    m_owner    = win;
                    m_val      = req_data[win*DW +: DW];
                    m_left     = (hv == 0) ? 1 : hv;
                    m_gnt[win] = 1'b1;
                    m_rr       = (win + 1) % N;
                end
            end
        end
        m_pcnt = (m_pcnt + 1) % PERIOD;
    endtask

    task automatic check_outputs();
        check_eq("value", digital_value, m_val);
        check_eq("busy", busy, m_busy);
        check_eq("gnt", gnt, m_gnt);
        check_eq("done", done, m_done);
        check_eq("tick", period_tick, m_tick);
        if (m_busy) check_eq("owner", owner, m_owner);
    endtask

    // One clock: model the edge, let the DUT take it, compare, then act as the requesters.
    task automatic step();
        model_next();
        @(posedge clk);
        #1;
        check_outputs();
        for (int i = 0; i < N; i++) begin
            if (m_gnt[i]) begin
                req[i] = 1'b0;
                if (rearm[i]) relift[i] = 1'b1;
            end else if (relift[i]) begin
                req[i]    = 1'b1;
                relift[i] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        relift = '0;
        check_outputs();
        check_eq("rst_owner", owner, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input int data, input int hold);
        req_data[i*DW +: DW] = DW'(data);
        req_hold[i*HW +: HW] = HW'(hold);
        req[i] = 1'b1;
    endtask

    initial begin
        int hits;
        int ndone;
        int next_tick;
        int nticks;
        int gk;
        bit seen;
        int order[$];
        int exp_order[5];

        exp_order = '{0, 1, 2, 3, 0};
        rst_n    = 1'b1;
        en       = 1'b1;
        req      = '0;
        req_data = '0;
        req_hold = '0;
        rearm    = '0;
        relift   = '0;
        model_reset();
        do_reset();

        // Idle for three periods; ticks only at 256, 512, 768.
        next_tick = PERIOD;
        nticks    = 0;
        for (int k = 1; k <= 3 * PERIOD; k++) begin
            step();
            if (period_tick) begin
                check_eq("tick_cycle", k, next_tick);
                next_tick += PERIOD;
                nticks++;
            end
        end
        check_eq("tick_count", nticks, 3);

        // Single requester, hold 2.
        set_req(0, 100, 2);
        hits = 0;
        for (int k = 0; k < 4 * PERIOD; k++) begin
            step();
            if (digital_value == 8'd100) hits++;
        end
        check_eq("hold2_cycles", hits, 2 * PERIOD);

        // All four, hold 1, re-raised after each grant.
        do_reset();
        set_req(0, 20, 1);
        set_req(1, 100, 1);
        set_req(2, 150, 1);
        set_req(3, 255, 1);
        rearm = '1;
        for (int k = 0; k < 5 * PERIOD + 20; k++) begin
            step();
            for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
            if (|done) check_eq("done_with_gnt", |gnt, 1);
        end
        check_eq("order_len", order.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            if (i < order.size()) check_eq("grant_order", order[i], exp_order[i]);
        end
        rearm  = '0;
        relift = '0;
        req    = '0;
        repeat (2 * PERIOD) step();

        // Hold 0 behaves as one period.
        set_req(2, 77, 0);
        hits = 0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            step();
            if (digital_value == 8'd77) hits++;
        end
        check_eq("hold0_cycles", hits, PERIOD);

        // Enable dropped in the second period of a hold of 5.
        set_req(1, 200, 5);
        hits  = 0;
        ndone = 0;
        seen  = 0;
        for (int k = 0; k < 2 * PERIOD && !seen; k++) begin
            step();
            seen = m_gnt[1];
            if (digital_value == 8'd200) hits++;
        end
        check_eq("en_grant_seen", seen, 1);
        for (int k = 0; k < PERIOD + 100; k++) begin
            step();
            if (digital_value == 8'd200) hits++;
            if (|done) ndone++;
        end
        en = 1'b0;
        for (int k = 0; k < PERIOD + 100; k++) begin
            step();
            if (digital_value == 8'd200) hits++;
            if (|done) ndone++;
        end
        check_eq("abort_cycles", hits, 2 * PERIOD);
        check_eq("abort_no_done", ndone, 0);
        check_eq("abort_busy", busy, 0);
        en = 1'b1;

        // Reset at pcnt=77 mid-hold, then a pending request wins the first boundary.
        set_req(3, 99, 3);
        seen = 0;
        for (int k = 0; k < 3 * PERIOD && !seen; k++) begin
            step();
            seen = m_busy && (m_pcnt == 77) && (m_owner == 3);
        end
        check_eq("rst_window_seen", seen, 1);
        set_req(1, 55, 1);
        do_reset();
        check_eq("rst_value", digital_value, IDLE);
        gk = -1;
        for (int k = 1; k <= PERIOD + 50; k++) begin
            step();
            if (gnt[1] && gk < 0) gk = k;
        end
        check_eq("rst_regrant_cycle", gk, PERIOD);
        repeat (2 * PERIOD) step();

        // Random traffic: sporadic requests, data churn after grant, rare enable toggles.
        for (int k = 0; k < 60 * PERIOD; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 199) == 0)
                    set_req(i, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
            end
            if ($urandom_range(0, 49) == 0) begin
                for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 3999) == 0) en = !en;
            step();
        end
        en  = 1'b1;
        req = '0;
        repeat (4 * PERIOD) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
